shift_arbiter: RTL and testbench

- Shares one shift datapath among NREQ requesters.
- The datapath is one instance each of shift_left, shift_right_unsigned and shift_right_signed.
- Round-robin arbitration, operand capture, a registered result stage, and a valid/ready response to a single consumer.
- Sits between the issue logic (multiple execution slots) and writeback, so the three combinational shifters are not replicated per slot.

---
 rtl/shift_arbiter_if.sv | 27 ++
 rtl/shift_arbiter.sv | 167 ++++++++++++++++
 tb/tb_shift_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/shift_arbiter_if.sv
// Request/response bundle between the execution slots, the shared shift
// arbiter and the writeback consumer.
interface shift_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 32
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ*5-1:0] req_shamt;
  logic [NREQ*2-1:0] req_op;
  logic              resp_valid;
  logic              resp_ready;
  logic [W-1:0]      resp_data;
  logic [1:0]        resp_id;
  logic              resp_err;

  modport master (
    output req_valid, req_data, req_shamt, req_op, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_data, req_shamt, req_op, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );
endinterface

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one set of 32-bit shifters (SLL/SRL/SRA)
// among four requesters, with a registered valid/ready result stage.
module shift_left (
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o
);
  assign y_o = a_i << shamt_i;
endmodule

module shift_right_unsigned (
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o
);
  assign y_o = a_i >> shamt_i;
endmodule

module shift_right_signed (
  input  logic [31:0] a_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o
);
  assign y_o = $unsigned($signed(a_i) >>> shamt_i);
endmodule

module shift_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic           clk,
  input  logic           reset_n,
  shift_arbiter_if.slave bus,
  output logic           busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t       state_q, state_d;
  logic [1:0]   rr_ptr_q, rr_ptr_d;
  logic [W-1:0] op_data_q, op_data_d;
  logic [4:0]   op_shamt_q, op_shamt_d;
  logic [1:0]   op_code_q, op_code_d;
  logic [1:0]   op_id_q, op_id_d;
  logic         resp_valid_q, resp_valid_d;
  logic [W-1:0] resp_data_q, resp_data_d;
  logic [1:0]   resp_id_q, resp_id_d;
  logic         resp_err_q, resp_err_d;

  logic [W-1:0]    slot_data  [NREQ];
  logic [4:0]      slot_shamt [NREQ];
  logic [1:0]      slot_op    [NREQ];
  logic [NREQ-1:0] grant;
  logic [1:0]      grant_id;
  logic [1:0]      probe;
  logic            grant_found;
  logic [W-1:0]    sll_y, srl_y, sra_y, sel_y;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_slot
      assign slot_data[gi]  = bus.req_data[gi*W +: W];
      assign slot_shamt[gi] = bus.req_shamt[gi*5 +: 5];
      assign slot_op[gi]    = bus.req_op[gi*2 +: 2];
    end
  endgenerate

  // Search starts at rr_ptr and wraps; the first valid requester wins.
  always_comb begin
    grant       = '0;
    grant_id    = 2'd0;
    grant_found = 1'b0;
    probe       = 2'd0;
    for (int k = 0; k < NREQ; k++) begin
      probe = rr_ptr_q + 2'(k);
      if (!grant_found && bus.req_valid[probe]) begin
        grant[probe] = 1'b1;
        grant_id     = probe;
        grant_found  = 1'b1;
      end
    end
  end

  shift_left           u_sll (.a_i(op_data_q), .shamt_i(op_shamt_q), .y_o(sll_y));
  shift_right_unsigned u_srl (.a_i(op_data_q), .shamt_i(op_shamt_q), .y_o(srl_y));
  shift_right_signed   u_sra (.a_i(op_data_q), .shamt_i(op_shamt_q), .y_o(sra_y));

  always_comb begin
    case (op_code_q)
      2'b00:   sel_y = sll_y;
      2'b01:   sel_y = srl_y;
      2'b10:   sel_y = sra_y;
      default: sel_y = op_data_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    op_data_d    = op_data_q;
    op_shamt_d   = op_shamt_q;
    op_code_d    = op_code_q;
    op_id_d      = op_id_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_data_d  = slot_data[grant_id];
          op_shamt_d = slot_shamt[grant_id];
          op_code_d  = slot_op[grant_id];
          op_id_d    = grant_id;
          rr_ptr_d   = grant_id + 2'd1;
          state_d    = EXEC;
        end
      end
      EXEC: begin
        resp_data_d  = sel_y;
        resp_id_d    = op_id_q;
        resp_err_d   = (op_code_q == 2'b11);
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= 2'd0;
      op_data_q    <= '0;
      op_shamt_q   <= '0;
      op_code_q    <= '0;
      op_id_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      op_data_q    <= op_data_d;
      op_shamt_q   <= op_shamt_d;
      op_code_q    <= op_code_d;
      op_id_q      <= op_id_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Grant is masked while reset is held so no requester sees an accept.
  assign bus.req_ready  = (state_q == IDLE && reset_n) ? grant : '0;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: single ops, arbitration order,
// backpressure, illegal op and mid-operation reset.
module tb_shift_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic busy;
  int   tests = 0;
  int   fails = 0;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load(input int id, input logic [31:0] d, input logic [4:0] s, input logic [1:0] op);
    bus.req_data[32*id +: 32] = d;
    bus.req_shamt[5*id +: 5]  = s;
    bus.req_op[2*id +: 2]     = op;
  endtask

  // One isolated request from requester id, response accepted immediately.
  task automatic do_req(input string name, input int id, input logic [31:0] d, input logic [4:0] s,
                        input logic [1:0] op, input logic [31:0] exp_data, input logic exp_err);
    logic [3:0] exp_grant;
    exp_grant = 4'b0001 << id;
    load(id, d, s, op);
    bus.req_valid = exp_grant;
    settle();
    check({name, "_grant"}, 32'(bus.req_ready), 32'(exp_grant));
    check({name, "_idle_busy"}, 32'(busy), 32'd0);
    tick();
    bus.req_valid = 4'b0000;
    check({name, "_exec_busy"}, 32'(busy), 32'd1);
    check({name, "_exec_rvalid"}, 32'(bus.resp_valid), 32'd0);
    check({name, "_exec_ready"}, 32'(bus.req_ready), 32'd0);
    tick();
    check({name, "_rvalid"}, 32'(bus.resp_valid), 32'd1);
    check({name, "_data"}, bus.resp_data, exp_data);
    check({name, "_id"}, 32'(bus.resp_id), 32'(id));
    check({name, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    $display("[TB] %s id=%0d data=%h shamt=%0d op=%0d -> resp %h err=%0b", name, id, d, s, op,
             bus.resp_data, bus.resp_err);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check({name, "_done_rvalid"}, 32'(bus.resp_valid), 32'd0);
    check({name, "_done_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.req_valid  = '0;
    bus.req_data   = '0;
    bus.req_shamt  = '0;
    bus.req_op     = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rvalid", 32'(bus.resp_valid), 32'd0);
    check("rst_data", bus.resp_data, 32'd0);
    check("rst_id", 32'(bus.resp_id), 32'd0);
    check("rst_err", 32'(bus.resp_err), 32'd0);
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    reset_n = 1'b1;
    tick();

    do_req("sll", 2, 32'h0000_00F0, 5'd4, 2'b00, 32'h0000_0F00, 1'b0);
    do_req("sra", 0, 32'h8000_0010, 5'd4, 2'b10, 32'hF800_0001, 1'b0);
    do_req("srl", 1, 32'h8000_0010, 5'd4, 2'b01, 32'h0800_0001, 1'b0);
    do_req("illegal", 3, 32'h1234_5678, 5'd7, 2'b11, 32'h1234_5678, 1'b1);
    do_req("shamt0_sra", 0, 32'h8765_4321, 5'd0, 2'b10, 32'h8765_4321, 1'b0);

    // Backpressure: rr_ptr is 1 here, only requester 2 asks.
    load(2, 32'h0000_0001, 5'd31, 2'b00);
    bus.req_valid = 4'b0100;
    settle();
    check("bp_grant", 32'(bus.req_ready), 32'h4);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      settle();
      check("bp_rvalid", 32'(bus.resp_valid), 32'd1);
      check("bp_data", bus.resp_data, 32'h8000_0000);
      check("bp_id", 32'(bus.resp_id), 32'd2);
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      tick();
    end
    $display("[TB] backpressure id=2 resp %h held 5 cycles", bus.resp_data);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_release_rvalid", 32'(bus.resp_valid), 32'd0);
    check("bp_next_grant", 32'(bus.req_ready), 32'h8);
    bus.req_valid = 4'b0000;

    // Round-robin from reset with all requesters valid and consumer always ready.
    reset_n = 1'b0;
    for (int r = 0; r < 4; r++) load(r, 32'(r + 1), 5'(r), 2'b00);
    bus.req_valid  = 4'b1111;
    bus.resp_ready = 1'b1;
    tick();
    check("rr_rst_ready", 32'(bus.req_ready), 32'd0);
    reset_n = 1'b1;
    settle();
    begin
      int exp_id;
      logic [31:0] exp_d;
      for (int g = 0; g < 5; g++) begin
        exp_id = g % 4;
        exp_d  = 32'(exp_id + 1) << exp_id;
        check("rr_grant", 32'(bus.req_ready), 32'(1 << exp_id));
        check("rr_idle_rvalid", 32'(bus.resp_valid), 32'd0);
        tick();
        check("rr_exec_rvalid", 32'(bus.resp_valid), 32'd0);
        tick();
        check("rr_rvalid", 32'(bus.resp_valid), 32'd1);
        check("rr_id", 32'(bus.resp_id), 32'(exp_id));
        check("rr_data", bus.resp_data, exp_d);
        $display("[TB] rr grant %0d id=%0d resp %h", g, bus.resp_id, bus.resp_data);
        tick();
      end
    end
    bus.req_valid  = 4'b0000;
    bus.resp_ready = 1'b0;

    // Mid-operation reset: rr_ptr is 1; requester 1 is accepted, then reset in EXEC.
    bus.req_valid = 4'b0010;
    settle();
    check("midrst_grant", 32'(bus.req_ready), 32'h2);
    tick();
    bus.req_valid = 4'b0000;
    check("midrst_exec_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    check("midrst_rvalid", 32'(bus.resp_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    bus.req_valid = 4'b1001;
    settle();
    check("midrst_ptr0", 32'(bus.req_ready), 32'h1);
    bus.req_valid = 4'b1000;
    settle();
    check("midrst_req3", 32'(bus.req_ready), 32'h8);
    bus.req_valid = 4'b0000;
    tick();
    tick();
    check("midrst_no_resp", 32'(bus.resp_valid), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    $display("[TB] mid-op reset discarded request, requester 3 granted 1000");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
